// File: rtl/rv32_mem_arbiter_pkg.sv
// rv32_mem_arbiter_pkg: shared RV32 constants plus the arbiter's response tag
// types.
//   owner_t    - which requester a memory access belongs to
//   resp_tag_t - one response-pipeline entry {valid, owner, err, is_store}
//   ERR_RDATA  - read data returned with an error response
//   addr_legal - word-aligned and inside the memory
package rv32_mem_arbiter_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   err;
    logic   is_store;
  } resp_tag_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/rv32_resp_pipe.sv
// rv32_resp_pipe: DEPTH-stage shift register of response tags. One entry is
// pushed every cycle (invalid when nothing was granted), so the tag leaving
// the last stage lines up with memory read data of the same access.
//   clk_i  clock
//   clr_i  synchronous clear; drops every in-flight entry
//   tag_i  tag of the access granted this cycle
//   tag_o  tag of the access granted DEPTH cycles ago
module rv32_resp_pipe
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  resp_tag_t tag_i,
  output resp_tag_t tag_o
);

  resp_tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port memory between instruction fetch
// (read only) and load/store. Data wins unless it has already taken
// MAX_DATA_BURST grants in a row while fetch waited. Illegal (misaligned or
// out-of-range) accesses are granted but never reach memory; they return an
// error response with ERR_RDATA.
//   clk_i, rst_i                        clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_gnt_o         fetch request / address / accept
//   if_rvalid_o/if_rdata_o/if_err_o     fetch response
//   d_req_i/d_we_i/d_addr_i/d_wdata_i   data request
//   d_gnt_o                             data accept
//   d_rvalid_o/d_rdata_o/d_err_o        load response, or store error
//   mem_en_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_rdata_i             memory port, read data MEM_LATENCY later
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned MAX_DATA_BURST = 4,
  localparam int unsigned AW            = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_err_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned BW = $clog2(MAX_DATA_BURST + 1);

  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          fetch_win, any_gnt, acc_legal;
  logic [31:0]   acc_addr, rdata_sel;
  resp_tag_t     tag_in, tag_out;
  logic          rsp_live;

  // ---- grant + memory strobe (combinational, same cycle as req) ----
  always_comb begin
    fetch_win   = if_req_i && (!d_req_i || burst_cnt_q == BW'(MAX_DATA_BURST));
    if_gnt_o    = !rst_i && fetch_win;
    d_gnt_o     = !rst_i && d_req_i && !fetch_win;
    any_gnt     = if_gnt_o || d_gnt_o;
    acc_addr    = if_gnt_o ? if_addr_i : d_addr_i;
    acc_legal   = addr_legal(acc_addr, MEM_WORDS);
    mem_en_o    = any_gnt && acc_legal;
    mem_we_o    = mem_en_o && d_gnt_o && d_we_i;
    mem_addr_o  = mem_en_o ? acc_addr[AW+1:2] : '0;
    mem_wdata_o = mem_we_o ? d_wdata_i : '0;

    tag_in = '0;
    if (any_gnt) begin
      tag_in.valid    = 1'b1;
      tag_in.owner    = if_gnt_o ? OWN_IF : OWN_D;
      tag_in.err      = !acc_legal;
      tag_in.is_store = d_gnt_o && d_we_i;
    end

    // Streak of data grants only counts while fetch is actually waiting.
    burst_cnt_d = burst_cnt_q;
    if (!if_req_i || if_gnt_o) burst_cnt_d = '0;
    else if (d_gnt_o)          burst_cnt_d = burst_cnt_q + BW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) burst_cnt_q <= '0;
    else       burst_cnt_q <= burst_cnt_d;
  end

  rv32_resp_pipe #(.DEPTH(MEM_LATENCY)) u_resp_pipe (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // ---- response routing ----
  // Outputs are also gated by rst_i so the reset cycle itself shows nothing,
  // even for the entry that was sitting at the pipe exit.
  always_comb begin
    rsp_live    = tag_out.valid && !rst_i;
    rdata_sel   = tag_out.err ? ERR_RDATA : mem_rdata_i;
    if_rvalid_o = rsp_live && tag_out.owner == OWN_IF;
    // Legal stores complete silently; only their errors are reported.
    d_rvalid_o  = rsp_live && tag_out.owner == OWN_D && (!tag_out.is_store || tag_out.err);
    if_rdata_o  = if_rvalid_o ? rdata_sel : '0;
    d_rdata_o   = d_rvalid_o  ? rdata_sel : '0;
    if_err_o    = if_rvalid_o && tag_out.err;
    d_err_o     = d_rvalid_o  && tag_out.err;
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter. Two DUTs (latency 1 and 3) share one request
// stream; each gets its own behavioural memory. A transaction-level model
// predicts grants, strobes and a timed response queue per DUT.
module tb_rv32_mem_arbiter;
  import rv32_mem_arbiter_pkg::*;

  localparam int W    = 64;
  localparam int AW   = 6;
  localparam int MAXB = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;

  logic [1:0]    if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en, mem_we;
  logic [31:0]   if_rdata [2];
  logic [31:0]   d_rdata [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];
  logic [AW-1:0] mem_addr [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rv32_mem_arbiter #(
      .MEM_WORDS(W), .MEM_LATENCY((g == 0) ? LAT0 : LAT1), .MAX_DATA_BURST(MAXB)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]), .if_err_o(if_err[g]),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt[g]), .d_rvalid_o(d_rvalid[g]), .d_rdata_o(d_rdata[g]), .d_err_o(d_err[g]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g])
    );
  end

  // ---- environment memories: contents loaded on the first edge ----
  logic [31:0] init_words [W];
  logic [31:0] emem [2][W];
  logic [31:0] rdp [2][4];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 3; i > 0; i--) rdp[k][i] <= rdp[k][i-1];
      rdp[k][0] <= (mem_en[k] && !mem_we[k]) ? emem[k][mem_addr[k]] : $urandom;
      if (!loaded) begin
        for (int i = 0; i < W; i++) emem[k][i] <= init_words[i];
      end else if (mem_en[k] && mem_we[k]) begin
        emem[k][mem_addr[k]] <= mem_wdata[k];
      end
    end
    loaded <= 1'b1;
  end

  assign mem_rdata[0] = rdp[0][LAT0-1];
  assign mem_rdata[1] = rdp[1][LAT1-1];

  // ---- reference model ----
  typedef struct {
    int          due;
    logic        own_d;
    logic        err;
    logic        st;
    logic [31:0] data;
  } exp_t;

  exp_t        expq [2][$];
  logic [31:0] mmem [W];
  int          streak, cyc, n_cmp, n_bad;
  logic        eg_if, eg_d;

  logic [1:0]    s_if_gnt, s_mem_en, s_if_rv, s_d_rv, s_d_err;
  logic [31:0]   s_if_rd [2];
  logic [31:0]   s_d_rd [2];
  logic [AW-1:0] s_maddr0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] cyc=%0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0] a;
    logic        legal, gany, st, v;
    exp_t        e;
    s_if_gnt = if_gnt; s_mem_en = mem_en; s_if_rv = if_rvalid; s_d_rv = d_rvalid;
    s_d_err = d_err; s_if_rd = if_rdata; s_d_rd = d_rdata; s_maddr0 = mem_addr[0];
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_if_gnt", k, 32'(if_gnt[k]), 0);
        chk("rst_d_gnt", k, 32'(d_gnt[k]), 0);
        chk("rst_mem_en", k, 32'(mem_en[k]), 0);
        chk("rst_mem_we", k, 32'(mem_we[k]), 0);
        chk("rst_if_rvalid", k, 32'(if_rvalid[k]), 0);
        chk("rst_d_rvalid", k, 32'(d_rvalid[k]), 0);
        chk("rst_if_err", k, 32'(if_err[k]), 0);
        chk("rst_d_err", k, 32'(d_err[k]), 0);
        chk("rst_if_rdata", k, if_rdata[k], 0);
        chk("rst_d_rdata", k, d_rdata[k], 0);
        expq[k].delete();
      end
      streak = 0; eg_if = 1'b0; eg_d = 1'b0;
    end else begin
      eg_if = if_req && (!d_req || streak == MAXB);
      eg_d  = d_req && !eg_if;
      gany  = eg_if || eg_d;
      a     = eg_if ? if_addr : d_addr;
      legal = (a % 4 == 0) && (a / 4 < W);
      st    = eg_d && d_we;
      for (int k = 0; k < 2; k++) begin
        chk("if_gnt", k, 32'(if_gnt[k]), 32'(eg_if));
        chk("d_gnt", k, 32'(d_gnt[k]), 32'(eg_d));
        chk("mem_en", k, 32'(mem_en[k]), 32'(gany && legal));
        chk("mem_we", k, 32'(mem_we[k]), 32'(st && legal));
        if (gany && legal) chk("mem_addr", k, 32'(mem_addr[k]), a / 4);
        if (st && legal) chk("mem_wdata", k, mem_wdata[k], d_wdata);
        v = 1'b0;
        if (expq[k].size() > 0 && expq[k][0].due == cyc) begin
          e = expq[k].pop_front();
          v = 1'b1;
        end
        chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(v && !e.own_d));
        chk("d_rvalid", k, 32'(d_rvalid[k]), 32'(v && e.own_d));
        if (v && !e.own_d) begin
          chk("if_rdata", k, if_rdata[k], e.data);
          chk("if_err", k, 32'(if_err[k]), 32'(e.err));
        end else chk("if_rdata_idle", k, if_rdata[k], 0);
        if (v && e.own_d) begin
          chk("d_err", k, 32'(d_err[k]), 32'(e.err));
          if (!e.st) chk("d_rdata", k, d_rdata[k], e.data);
        end else chk("d_rdata_idle", k, d_rdata[k], 0);
      end
      if (gany && !(st && legal)) begin
        for (int k = 0; k < 2; k++)
          expq[k].push_back('{due: cyc + ((k == 0) ? LAT0 : LAT1), own_d: eg_d, err: !legal,
                              st: st, data: legal ? mmem[a / 4] : 32'hDEADBEEF});
      end
      if (st && legal) mmem[a / 4] = d_wdata;
      if (!if_req || eg_if) streak = 0;
      else if (eg_d) streak++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'($urandom_range(0, W - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'(W * 4 + $urandom_range(0, 255) * 4);
    return 32'($urandom_range(0, W - 1) * 4);
  endfunction

  initial begin
    logic [9:0] pat;
    int         rv_cnt;
    n_cmp = 0; n_bad = 0; streak = 0; cyc = 0; eg_if = 1'b0; eg_d = 1'b0;
    for (int i = 0; i < W; i++) init_words[i] = $urandom;
    init_words[0] = 32'hA0A00000;
    init_words[1] = 32'hB1B10001;
    init_words[4] = 32'h12345678;
    for (int i = 0; i < W; i++) mmem[i] = init_words[i];
    @(posedge clk); #1;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // fetch only
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk("lit_fetch_gnt", 0, 32'(s_if_gnt[0]), 1);
    chk("lit_fetch_addr", 0, 32'(s_maddr0), 4);
    tick();
    chk("lit_fetch_rvalid", 0, 32'(s_if_rv[0]), 1);
    chk("lit_fetch_rdata", 0, s_if_rd[0], 32'h12345678);
    repeat (2) tick();

    // contention: D,D,D,D,IF,D,D,D,D,IF (bit i = 1 means fetch granted)
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; if_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat[i] = s_if_gnt[0];
    end
    chk("lit_contention", 0, 32'(pat), 32'b1000010000);
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE0001;
    tick();
    d_we = 1'b0;
    tick();
    chk("lit_store_noresp", 0, 32'(s_d_rv[0]), 0);
    d_req = 1'b0;
    tick();
    chk("lit_load_rvalid", 0, 32'(s_d_rv[0]), 1);
    chk("lit_load_rdata", 0, s_d_rd[0], 32'hCAFE0001);
    chk("lit_load_err", 0, 32'(s_d_err[0]), 0);
    repeat (3) tick();

    // illegal accesses
    d_req = 1'b1; d_addr = 32'h22;
    tick();
    chk("lit_misalign_en", 0, 32'(s_mem_en[0]), 0);
    d_addr = 32'(W * 4);
    tick();
    chk("lit_range_en", 0, 32'(s_mem_en[0]), 0);
    chk("lit_misalign_err", 0, 32'(s_d_err[0]), 1);
    chk("lit_misalign_rdata", 0, s_d_rd[0], 32'hDEADBEEF);
    d_req = 1'b0;
    tick();
    chk("lit_range_err", 0, 32'(s_d_err[0]), 1);
    chk("lit_range_rdata", 0, s_d_rd[0], 32'hDEADBEEF);
    repeat (4) tick();

    // latency 3: D load 0x4 then IF fetch 0x0
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_addr = 32'h4; d_we = 1'b0;
    tick();
    d_req = 1'b0;
    tick();
    if_req = 1'b0;
    tick();
    tick();
    chk("lit_lat3_d_rvalid", 1, 32'(s_d_rv[1]), 1);
    chk("lit_lat3_d_rdata", 1, s_d_rd[1], 32'hB1B10001);
    tick();
    chk("lit_lat3_if_rvalid", 1, 32'(s_if_rv[1]), 1);
    chk("lit_lat3_if_rdata", 1, s_if_rd[1], 32'hA0A00000);
    repeat (3) tick();

    // reset while two reads are in flight
    d_req = 1'b1; d_addr = 32'h4;
    tick();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    tick();
    if_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    rv_cnt = 0;
    repeat (5) begin
      tick();
      rv_cnt += int'(s_if_rv[1]) + int'(s_d_rv[1]);
    end
    chk("lit_rst_flush", 1, 32'(rv_cnt), 0);

    // random traffic; a request is held until the model says it was granted
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || eg_if) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = rand_addr();
      end
      if (!d_req || eg_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-port unified memory between the RV32 core's instruction-fetch port and its load/store port.
- Arbitrates per cycle: data accesses have priority, bounded by a starvation limit so fetch always progresses.
- Memory reads are pipelined with a fixed latency; each response is routed back to the requester that issued it.
- Out-of-range and misaligned accesses are rejected with an error response and never reach the memory.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; AW = $clog2(MEM_WORDS).
- MEM_LATENCY, 1, cycles from mem_en_o (read) to valid mem_rdata_i; legal range 1..4.
- MAX_DATA_BURST, 4, maximum consecutive data grants while a fetch request is pending.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request (read only)
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  32  fetch response data
- if_err_o  out  1  fetch response is an error
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  load response valid
- d_rdata_o  out  32  load response data
- d_err_o  out  1  load/store error response
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  word address (byte address[AW+1:2])
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid MEM_LATENCY cycles after a read strobe

Behaviour:
- Grant logic is combinational from the requests and registered state. At most one grant per cycle; gnt is asserted in the same cycle as req.
- Requesters hold req, addr, we and wdata stable until gnt.
- Priority: d_req_i wins over if_req_i unless burst_cnt == MAX_DATA_BURST with if_req_i high. In that case fetch wins and burst_cnt clears.
- burst_cnt updates:
  - increments on a data grant while if_req_i is high;
  - clears on any fetch grant;
  - clears on any cycle where if_req_i is low.
- mem_en_o / mem_we_o / mem_addr_o / mem_wdata_o are driven combinationally in the grant cycle, only for a legal granted access.
- Legal access: addr[1:0] == 0 and addr[31:2] < MEM_WORDS. An illegal granted access is not issued to memory (mem_en_o = 0).
- Response pipeline: a shift register of MEM_LATENCY entries {valid, owner(IF/D), err, is_store}. Each grant pushes an entry; cycles with no grant push an invalid entry. This gives full throughput with one access per cycle.
- On pipeline exit:
  - legal load or fetch: assert the owner's rvalid with rdata = mem_rdata_i and err = 0;
  - illegal load or fetch: rvalid = 1, err = 1, rdata = 32'hDEADBEEF;
  - legal store: produces no response;
  - illegal store: d_rvalid_o = 1, d_err_o = 1.
- The owner's rdata is 0 whenever its rvalid is low.
- Response order equals grant order. The latency from grant to rvalid is exactly MEM_LATENCY cycles.
- Simultaneous events: both requests in the same cycle grant only one; the loser keeps requesting.
- Reset (synchronous, any time):
  - all outputs go to 0 and burst_cnt clears;
  - all in-flight pipeline entries are discarded, so no rvalid is ever produced for a pre-reset grant;
  - while rst_i is high, no grants are issued.

Decomposition:
- Add to the shared package (alongside the RV32 opcode constants):
  - typedef owner_t enum {OWN_IF, OWN_D};
  - struct resp_tag_t {valid, owner, err, is_store};
  - localparam ERR_RDATA = 32'hDEADBEEF.
- One natural sub-module: rv32_resp_pipe, a parameterised MEM_LATENCY-deep shift register of resp_tag_t with synchronous clear.

Test Plan:
- Fetch only: if_req_i = 1, if_addr_i = 0x10 every cycle, MEM_LATENCY = 1 -> if_gnt_o = 1 every cycle; mem_addr_o = 4; if_rvalid_o one cycle later carrying mem[4].
- Contention: both requests held high, MAX_DATA_BURST = 4 -> grant pattern D,D,D,D,IF,D,D,D,D,IF; no starvation.
- Store then load: store 0xCAFE0001 to 0x20, then load 0x20 -> store gives no d_rvalid_o; load returns d_rdata_o = 0xCAFE0001 with d_err_o = 0.
- Illegal access: load 0x22 and load MEM_WORDS*4 -> mem_en_o = 0 in both grant cycles; d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0xDEADBEEF after MEM_LATENCY cycles.
- Latency 3, interleaved IF/D reads at 0x0 and 0x4 -> responses arrive exactly 3 cycles after each grant, in grant order, to the correct owner.
- Reset mid-flight: grant 2 reads with MEM_LATENCY = 3, assert rst_i for 1 cycle before they return -> no rvalid on either port afterwards; all outputs 0 during reset.
